fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the PC plus instruction-memory datapath (`PC_Instr_Mem`). It drives that block's `i_PC`, `din` and `we` inputs. In LOAD mode it streams a program into instruction memory through a valid/ready handshake. In RUN mode it steps the PC each cycle, applying stall, jump and halt requests from the decoder. It sits between the program-load port and the PC/instruction-memory pair, and is the only block that drives the PC.

## Interface
Parameters:
- addr_width, 8, PC and memory address width; must match `PC_Instr_Mem`
- data_width, 16, instruction word width
- active_edge, `POS_EDGE`, clock edge for all registers (`edge_macro.v` encoding); must match `PC_Instr_Mem`

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- load_start  in  1  pulse in IDLE: begin loading at address 0
- load_valid  in  1  load_data holds a word
- load_data  in  data_width  program word
- load_last  in  1  qualifies the final word of the program
- load_ready  out  1  controller accepts a word this cycle
- run_start  in  1  pulse in IDLE or HALT: begin execution at address 0
- stall  in  1  freeze PC this cycle (RUN only)
- jump  in  1  take jump_addr as next PC (RUN only)
- jump_addr  in  addr_width  jump target
- halt  in  1  stop execution (RUN only)
- pc  in  addr_width  current PC, from `PC_Instr_Mem.r_PC`
- next_pc  out  addr_width  to `PC_Instr_Mem.i_PC`
- mem_we  out  1  to `PC_Instr_Mem.we`
- mem_din  out  data_width  to `PC_Instr_Mem.din`
- state  out  3  IDLE=0, ZERO=1, LOAD=2, RUN=3, HALT=4
- load_count  out  addr_width+1  words written by the last load
- load_err  out  1  last load ran past the top address without load_last

## Operation
- Registers: state, target (load/run, 1 bit), load_count, load_err. All other outputs are combinational from state, pc and the inputs.
- The PC register belongs to `PC_Instr_Mem`. The RAM writes at `pc` on the same edge on which the PC takes `next_pc`.
- Default when not otherwise specified: next_pc=pc, mem_we=0, load_ready=0. mem_din=load_data always.

States:
- **IDLE**
  - next_pc=pc.
  - load_start → ZERO with target=load; clears load_count and load_err.
  - Otherwise run_start → ZERO with target=run.
  - load_start has priority over run_start.
- **ZERO**
  - next_pc=0 for exactly one cycle.
  - Then → LOAD or RUN according to target.
- **LOAD**
  - load_ready=1.
  - On load_valid: mem_we=1, next_pc=pc+1 (mod 2^addr_width), load_count+=1.
  - Accepted word with load_last → IDLE.
  - Accepted word at pc=2^addr_width−1 without load_last: the word is written, load_err=1, → IDLE.
  - No load_valid → hold.
- **RUN**, priority stall > halt > jump > increment:
  - stall: next_pc=pc.
  - halt: next_pc=pc, → HALT.
  - jump: next_pc=jump_addr.
  - else: next_pc=pc+1; wraps from 2^addr_width−1 to 0.
- **HALT**
  - next_pc=pc.
  - run_start → ZERO with target=run. load_start is ignored.

Other rules:
- load_start and run_start are ignored in ZERO, LOAD and RUN.
- jump, halt and stall are ignored outside RUN.
- mem_we is never 1 outside LOAD.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, target=load, load_count=0, load_err=0.
  - Combinational outputs follow IDLE: next_pc=pc, mem_we=0, load_ready=0.
- Reset mid-load aborts immediately; words already written remain in memory.
- The PC itself is reset only by `PC_Instr_Mem`'s own reset.
- Start latency: command edge → ZERO (next_pc=0) → next edge pc=0 and state=LOAD/RUN.
  - The first word is written to address 0, or the first instruction is fetched at 0, in the cycle after ZERO.
- Load throughput: one word per cycle when load_valid stays high.
  - A handshake completes on an active edge with load_valid=1 and load_ready=1.
- Jump: pc=jump_addr one edge after jump is sampled. Halt: PC frozen from that edge onward.
- load_count saturates at 2^addr_width.

## Test plan
- Reset then load_start, 4 words 0xA001..0xA004 back-to-back, last on the 4th: writes at addresses 0..3, load_count=4, return to IDLE with pc=4, load_err=0.
- Load with load_valid toggling every other cycle: writes occur only on valid cycles, addresses stay contiguous 0..N−1, PC holds during gaps.
- Load of 256 words (addr_width=8) without load_last: all addresses written, load_err=1, load_count=256, pc wraps to 0, state IDLE.
- run_start, then jump=1 with jump_addr=0x40 at pc=5, stall at pc=0x41, halt at pc=0x42: PC sequence 0,1,…,5,0x40,0x41,0x41,0x42, then HALT with pc frozen at 0x42; run_start from HALT restarts at 0.
- RUN with pc=0xFF and no jump: next pc=0x00. halt and jump asserted together: halt wins. stall and halt asserted together: PC holds and state stays RUN.
- rst pulled low mid-load after 2 words: state=IDLE and load_count=0 immediately. A simultaneous load_start and run_start in IDLE enters LOAD.

Source files
------------

// File: rtl/fetch_ctrl.sv
// PC sequencing controller for the PC / instruction-memory pair: streams a
// program into memory in LOAD mode and steps the PC in RUN mode.
module fetch_ctrl #(
  parameter int addr_width  = 8,
  parameter int data_width  = 16,
  parameter int active_edge = 1   // 1 = rising edge (POS_EDGE), 0 = falling edge
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [data_width-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  run_start,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [addr_width-1:0] jump_addr,
  input  logic                  halt,
  input  logic [addr_width-1:0] pc,
  output logic [addr_width-1:0] next_pc,
  output logic                  mem_we,
  output logic [data_width-1:0] mem_din,
  output logic [2:0]            state,
  output logic [addr_width:0]   load_count,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZERO = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [addr_width:0]   count_max = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width-1:0] top_addr  = {addr_width{1'b1}};

  state_t                state_q, state_d;
  logic                  target_run_q, target_run_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic [addr_width-1:0] pc_inc;
  logic                  clk_int;

  // Registers share the edge the PC/memory block uses.
  assign clk_int = (active_edge != 0) ? clk : ~clk;
  assign pc_inc  = pc + {{(addr_width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_int or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      target_run_q <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_run_q <= target_run_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Load handshake: a word transfers on an active edge where load_valid and
  // load_ready are both high; load_ready is high for every LOAD cycle and
  // load_data must be held stable while load_valid waits for it.
  always_comb begin
    state_d      = state_q;
    target_run_d = target_run_q;
    count_d      = count_q;
    err_d        = err_q;
    next_pc      = pc;
    mem_we       = 1'b0;
    load_ready   = 1'b0;
    mem_din      = load_data;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d      = S_ZERO;
          target_run_d = 1'b0;
          count_d      = '0;
          err_d        = 1'b0;
        end else if (run_start) begin
          state_d      = S_ZERO;
          target_run_d = 1'b1;
        end
      end
      S_ZERO: begin
        next_pc = '0;
        state_d = target_run_q ? S_RUN : S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we  = 1'b1;
          next_pc = pc_inc;
          if (count_q != count_max) count_d = count_q + 1'b1;
          if (load_last) begin
            state_d = S_IDLE;
          end else if (pc == top_addr) begin
            // Memory is full and the program has not ended: stop and flag it.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (stall) begin
          next_pc = pc;
        end else if (halt) begin
          next_pc = pc;
          state_d = S_HALT;
        end else if (jump) begin
          next_pc = jump_addr;
        end else begin
          next_pc = pc_inc;
        end
      end
      S_HALT: begin
        if (run_start) begin
          state_d      = S_ZERO;
          target_run_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state      = state_q;
  assign load_count = count_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a behavioural PC register and instruction memory
// around it; memory writes are scored against an expected queue.
module tb_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  localparam logic [6:0] LS = 7'b1000000;
  localparam logic [6:0] LV = 7'b0100000;
  localparam logic [6:0] LL = 7'b0010000;
  localparam logic [6:0] RS = 7'b0001000;
  localparam logic [6:0] ST = 7'b0000100;
  localparam logic [6:0] JP = 7'b0000010;
  localparam logic [6:0] HT = 7'b0000001;

  typedef struct {
    logic [6:0]    ctl;
    logic [AW-1:0] ja;
    logic [DW-1:0] d;
    logic [2:0]    e_state;
    logic [AW-1:0] e_npc;
    logic          e_we;
    logic          e_rdy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, pc_rst_n;
  logic          load_start, load_valid, load_last, load_ready;
  logic [DW-1:0] load_data, mem_din;
  logic          run_start, stall, jump, halt, mem_we, load_err;
  logic [AW-1:0] jump_addr, pc, next_pc;
  logic [2:0]    state;
  logic [AW:0]   load_count;

  logic [DW-1:0] mem [0:255];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  vec_t          vecs[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.addr_width(AW), .data_width(DW), .active_edge(1)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .run_start(run_start), .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .halt(halt), .pc(pc), .next_pc(next_pc), .mem_we(mem_we), .mem_din(mem_din),
    .state(state), .load_count(load_count), .load_err(load_err)
  );

  // PC register and RAM of the datapath being sequenced.
  always @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) pc <= '0;
    else           pc <= next_pc;
  end

  always @(posedge clk) begin
    if (mem_we) mem[pc] <= mem_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", pc, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", 32'({pc, mem_din}), 32'(mon_e));
      end
    end
  end

  function automatic vec_t mkv(input logic [6:0] c, input logic [AW-1:0] ja,
                               input logic [DW-1:0] d, input logic [2:0] st,
                               input logic [AW-1:0] npc, input logic we, input logic rdy);
    vec_t v;
    v.ctl = c; v.ja = ja; v.d = d;
    v.e_state = st; v.e_npc = npc; v.e_we = we; v.e_rdy = rdy;
    return v;
  endfunction

  task automatic idle_inputs();
    {load_start, load_valid, load_last, run_start, stall, jump, halt} = 7'b0;
    jump_addr = '0;
    load_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    {load_start, load_valid, load_last, run_start, stall, jump, halt} = v.ctl;
    jump_addr = v.ja;
    load_data = v.d;
    if (v.e_we) exp_q.push_back({v.e_npc - 8'd1, v.d});
    #1;
    check($sformatf("vec%0d_state", idx), 32'(state), 32'(v.e_state));
    check($sformatf("vec%0d_next_pc", idx), 32'(next_pc), 32'(v.e_npc));
    check($sformatf("vec%0d_mem_we", idx), 32'(mem_we), 32'(v.e_we));
    check($sformatf("vec%0d_load_ready", idx), 32'(load_ready), 32'(v.e_rdy));
    cyc();
  endtask

  initial begin
    logic [DW-1:0] d, d0, d1;
    int widx;
    logic v;

    rst = 1'b0;
    pc_rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_next_pc", 32'(next_pc), 32'd0);
    cyc(); cyc();
    rst = 1'b1;
    pc_rst_n = 1'b1;

    // 4-word load (load_start wins over run_start), then the RUN sequence.
    vecs.push_back(mkv(0,     0, 0,        0, 0, 0, 0));
    vecs.push_back(mkv(LS|RS, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        1, 0, 0, 0));
    vecs.push_back(mkv(LV,    0, 16'hA001, 2, 1, 1, 1));
    vecs.push_back(mkv(LV,    0, 16'hA002, 2, 2, 1, 1));
    vecs.push_back(mkv(LV,    0, 16'hA003, 2, 3, 1, 1));
    vecs.push_back(mkv(LV|LL, 0, 16'hA004, 2, 4, 1, 1));
    vecs.push_back(mkv(0,     0, 0,        0, 4, 0, 0));
    vecs.push_back(mkv(RS,    0, 0,        0, 4, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        1, 0, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 1, 0, 0));
    vecs.push_back(mkv(LV,    0, 16'h5555, 3, 2, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 3, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 4, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 5, 0, 0));
    vecs.push_back(mkv(JP,    8'h40, 0,    3, 8'h40, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 8'h41, 0, 0));
    vecs.push_back(mkv(ST,    0, 0,        3, 8'h41, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 8'h42, 0, 0));
    vecs.push_back(mkv(HT,    0, 0,        3, 8'h42, 0, 0));
    vecs.push_back(mkv(JP|ST, 8'h10, 0,    4, 8'h42, 0, 0));
    vecs.push_back(mkv(LS|LV, 0, 16'h1234, 4, 8'h42, 0, 0));
    vecs.push_back(mkv(RS,    0, 0,        4, 8'h42, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        1, 0, 0, 0));
    vecs.push_back(mkv(ST|HT, 0, 0,        3, 0, 0, 0));
    vecs.push_back(mkv(HT|JP, 8'h80, 0,    3, 0, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        4, 0, 0, 0));
    vecs.push_back(mkv(RS,    0, 0,        4, 0, 0, 0));
    vecs.push_back(mkv(LS|RS, 0, 0,        1, 0, 0, 0));
    vecs.push_back(mkv(JP,    8'hFF, 0,    3, 8'hFF, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        3, 8'h00, 0, 0));
    vecs.push_back(mkv(HT,    0, 0,        3, 0, 0, 0));
    vecs.push_back(mkv(0,     0, 0,        4, 0, 0, 0));

    cyc();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
    idle_inputs();
    #1;
    check("tbl_count", 32'(load_count), 32'd4);
    check("tbl_err", 32'(load_err), 32'd0);

    // Reset the controller only; PC keeps its value.
    rst = 1'b0;
    #1;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_count", 32'(load_count), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // Load with load_valid toggling: five words on even cycles.
    load_start = 1'b1;
    #1;
    check("tog_idle_next_pc", 32'(next_pc), 32'(pc));
    cyc();
    load_start = 1'b0;
    #1;
    check("tog_zero_state", 32'(state), 32'd1);
    check("tog_zero_next_pc", 32'(next_pc), 32'd0);
    cyc();
    widx = 0;
    for (int i = 0; i < 9; i++) begin
      v = (i % 2 == 0);
      d = 16'($urandom_range(0, 16'hFFFF));
      load_valid = v;
      load_last  = (i == 8);
      load_data  = d;
      if (v) exp_q.push_back({8'(widx), d});
      #1;
      check($sformatf("tog%0d_pc", i), 32'(pc), 32'(widx));
      check($sformatf("tog%0d_we", i), 32'(mem_we), 32'(v));
      check($sformatf("tog%0d_next_pc", i), 32'(next_pc), 32'(v ? widx + 1 : widx));
      check($sformatf("tog%0d_ready", i), 32'(load_ready), 32'd1);
      cyc();
      if (v) widx++;
    end
    idle_inputs();
    #1;
    check("tog_state", 32'(state), 32'd0);
    check("tog_count", 32'(load_count), 32'd5);
    check("tog_pc", 32'(pc), 32'd5);
    check("tog_err", 32'(load_err), 32'd0);

    // Full-memory load without load_last.
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    cyc();
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      load_valid = 1'b1;
      load_data  = d;
      exp_q.push_back({8'(i), d});
      if (i == 255) begin
        #1;
        check("full_last_next_pc", 32'(next_pc), 32'd0);
        check("full_last_state", 32'(state), 32'd2);
      end
      cyc();
    end
    idle_inputs();
    #1;
    check("full_state", 32'(state), 32'd0);
    check("full_err", 32'(load_err), 32'd1);
    check("full_count", 32'(load_count), 32'd256);
    check("full_pc", 32'(pc), 32'd0);

    // Reset in the middle of a load.
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    #1;
    check("abort_zero_count", 32'(load_count), 32'd0);
    check("abort_zero_err", 32'(load_err), 32'd0);
    cyc();
    d0 = 16'hBEEF;
    d1 = 16'hCAFE;
    load_valid = 1'b1;
    load_data = d0;
    exp_q.push_back({8'd0, d0});
    cyc();
    load_data = d1;
    exp_q.push_back({8'd1, d1});
    cyc();
    check("abort_count2", 32'(load_count), 32'd2);
    load_valid = 1'b1;
    load_data = 16'h0BAD;
    rst = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_count", 32'(load_count), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd0);
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    check("abort_mem0", 32'(mem[0]), 32'(d0));
    check("abort_mem1", 32'(mem[1]), 32'(d1));
    check("abort_pc", 32'(pc), 32'd2);

    cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
